// File: rtl/hex_scan_driver.sv
// +----------------------------------------------------------------------------+
// | hex_scan_driver                                                            |
// | Time-multiplexes a shadowed hex value onto one 7-seg decoder + anodes,     |
// | with dead time between digits. Option: HEX_SCAN_LEADING_ZERO_BLANK_EN.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module hex_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 8
) (
  input  logic                                            clk_i,
  input  logic                                            rst_i,
  input  logic [4*DIGITS-1:0]                             data_i,
  input  logic                                            load_i,
  input  logic                                            scan_en_i,
  output logic [3:0]                                      hex_o,
  output logic                                            en_o,
  output logic [DIGITS-1:0]                               an_o,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0]  digit_idx_o
);

  localparam int IDX_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_MAX = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam bit HAS_DEAD = (DEAD_CYCLES > 0);

  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DIGITS - 1);

  localparam logic [0:0] S_DEAD  = 1'b0;
  localparam logic [0:0] S_DRIVE = 1'b1;

  logic [0:0]          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [3:0]          hex_q, hex_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                en_q, en_d;

  logic dead_done;
  logic drive_done;
  logic enter_drive;
  logic go_dark;
  logic blank;

  assign dead_done  = !HAS_DEAD || (cnt_q == DEAD_LAST);
  assign drive_done = (cnt_q == DRIVE_LAST);

  // Entry covers DEAD->DRIVE and the DRIVE->DRIVE rollover when there is no dead time.
  assign enter_drive = scan_en_i && (state_d == S_DRIVE) &&
                       ((state_q == S_DEAD) || drive_done);
  assign go_dark     = !scan_en_i || ((state_q == S_DRIVE) && drive_done && HAS_DEAD);

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] upper_zero;

  for (genvar k = 0; k < DIGITS; k++) begin : g_upper_zero
    assign upper_zero[k] = (shadow_q[4*DIGITS-1:4*k] == '0);
  end

  assign blank = (idx_d != '0) && upper_zero[idx_d];
`else
  assign blank = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_DEAD;
      cnt_q    <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      hex_q    <= '0;
      an_q     <= '1;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      hex_q    <= hex_d;
      an_q     <= an_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shadow_d = load_i ? data_i : shadow_q;
    if (!scan_en_i) begin
      state_d = S_DEAD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_DEAD: begin
          if (dead_done) begin
            state_d = S_DRIVE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DRIVE: begin
          if (drive_done) begin
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            cnt_d   = '0;
            state_d = HAS_DEAD ? S_DEAD : S_DRIVE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_DEAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Old shadow contents are latched at entry, so a coincident LOAD shows next time.
  always_comb begin
    hex_d = hex_q;
    an_d  = an_q;
    en_d  = en_q;
    if (go_dark) begin
      an_d = '1;
      en_d = 1'b0;
    end else if (enter_drive) begin
      hex_d = shadow_q[4*idx_d +: 4];
      if (blank) begin
        an_d = '1;
        en_d = 1'b0;
      end else begin
        an_d = ~(DIGITS'(1) << idx_d);
        en_d = 1'b1;
      end
    end
  end

  assign hex_o       = hex_q;
  assign en_o        = en_q;
  assign an_o        = an_q;
  assign digit_idx_o = idx_q;

endmodule

`default_nettype wire
